// File: rtl/dda_trace_buffer.sv
// Decimating capture FIFO for the Van der Pol DDA state pair (x, y).
// Kept steps are packed as {x, y} and drained one word per read request.
module dda_trace_buffer #(
  parameter int N       = 16,
  parameter int DEPTH   = 8,
  parameter int DECIM_W = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       step,
  input  logic [N-1:0]               x,
  input  logic [N-1:0]               y,
  input  logic [DECIM_W-1:0]         decim,
  input  logic                       clear,
  input  logic                       rd_req,
  output logic [2*N-1:0]             rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [2*N-1:0]     mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DECIM_W-1:0] dcnt_q, dcnt_d;
  logic [2*N-1:0]     rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  logic full_w, empty_w, capture, pop, push, drop;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  // clear masks both request types; a pop in the same cycle frees a slot for a capture
  assign capture = step && !clear && (dcnt_q == '0);
  assign pop     = rd_req && !clear && !empty_w;
  assign push    = capture && (!full_w || pop);
  assign drop    = capture && full_w && !pop;

  always_comb begin
    dcnt_d     = dcnt_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear) begin
      dcnt_d     = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (step) begin
        dcnt_d = (dcnt_q == '0) ? decim : dcnt_q - DECIM_W'(1);
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
      if (drop) begin
        overflow_d = 1'b1;
        drop_d     = sat_inc8(drop_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      dcnt_q     <= dcnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Storage is left unreset; a full-and-pop cycle reads the old word before it is overwritten
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {x, y};
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign empty    = empty_w;
  assign full     = full_w;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_dda_trace_buffer.sv
// Bench for dda_trace_buffer: queue-based reference model checked every cycle,
// plus directed scenarios with literal expected values.
module tb_dda_trace_buffer;

  localparam int N       = 16;
  localparam int DEPTH   = 8;
  localparam int DECIM_W = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic               clk, rst, step, clear, rd_req;
  logic [N-1:0]       x, y;
  logic [DECIM_W-1:0] decim;
  logic [2*N-1:0]     rd_data;
  logic               rd_valid, empty, full, overflow;
  logic [CW-1:0]      count;
  logic [7:0]         drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  dda_trace_buffer #(.N(N), .DEPTH(DEPTH), .DECIM_W(DECIM_W)) dut (
    .clk(clk), .rst(rst), .step(step), .x(x), .y(y), .decim(decim),
    .clear(clear), .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word queue plus "steps skipped since the last kept step"
  logic [2*N-1:0] m_q[$];
  logic [2*N-1:0] m_rd_data;
  bit             m_rd_valid, m_ovf, m_first, take;
  int             m_drop, m_skip, m_keep;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      m_rd_data  = '0;
      m_rd_valid = 0;
      m_ovf      = 0;
      m_drop     = 0;
      m_first    = 1;
      m_skip     = 0;
      m_keep     = 0;
    end else begin
      m_rd_valid = 0;
      if (clear) begin
        m_q.delete();
        m_ovf   = 0;
        m_drop  = 0;
        m_first = 1;
        m_skip  = 0;
      end else begin
        take = 0;
        if (step) begin
          if (m_first || m_skip == m_keep) begin
            take    = 1;
            m_first = 0;
            m_keep  = int'(decim);
            m_skip  = 0;
          end else begin
            m_skip++;
          end
        end
        if (rd_req && m_q.size() > 0) begin
          m_rd_data  = m_q.pop_front();
          m_rd_valid = 1;
        end
        if (take) begin
          if (m_q.size() < DEPTH) m_q.push_back({x, y});
          else begin
            m_ovf = 1;
            if (m_drop < 255) m_drop++;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("m_rd_valid", 64'(rd_valid), 64'(m_rd_valid));
      chk("m_rd_data", 64'(rd_data), 64'(m_rd_data));
      chk("m_count", 64'(count), 64'(m_q.size()));
      chk("m_empty", 64'(empty), 64'(m_q.size() == 0));
      chk("m_full", 64'(full), 64'(m_q.size() == DEPTH));
      chk("m_overflow", 64'(overflow), 64'(m_ovf));
      chk("m_drop_cnt", 64'(drop_cnt), 64'(m_drop));
    end
  end

  task automatic cyc(input bit st, input bit rr, input bit cl,
                     input logic [N-1:0] xv, input logic [N-1:0] yv);
    @(negedge clk);
    step   = st;
    rd_req = rr;
    clear  = cl;
    x      = xv;
    y      = yv;
  endtask

  task automatic idle();
    cyc(0, 0, 0, '0, '0);
  endtask

  task automatic pop_chk(input string name, input logic [2*N-1:0] exp);
    cyc(0, 1, 0, '0, '0);
    idle();
    chk({name, "_valid"}, 64'(rd_valid), 64'd1);
    chk(name, 64'(rd_data), 64'(exp));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_empty"}, 64'(empty), 64'd1);
    chk({tag, "_full"}, 64'(full), 64'd0);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
    chk({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
  endtask

  initial begin
    rst = 1'b1; step = 0; rd_req = 0; clear = 0; x = '0; y = '0; decim = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;

    // Basic capture and drain, every step kept
    decim = 8'd0;
    cyc(1, 0, 0, 16'h3000, 16'h3000);
    cyc(1, 0, 0, 16'h3100, 16'h2F00);
    cyc(1, 0, 0, 16'h3200, 16'h2E00);
    idle();
    chk("t1_count", 64'(count), 64'd3);
    pop_chk("t1_pop0", 32'h30003000);
    pop_chk("t1_pop1", 32'h31002F00);
    pop_chk("t1_pop2", 32'h32002E00);
    chk("t1_empty", 64'(empty), 64'd1);

    // decim=2 keeps steps 1, 4, 7
    cyc(0, 0, 1, '0, '0);
    decim = 8'd2;
    for (int i = 1; i <= 9; i++) cyc(1, 0, 0, 16'(i), 16'h0000);
    idle();
    chk("t2_count", 64'(count), 64'd3);
    pop_chk("t2_pop_x1", 32'h00010000);
    pop_chk("t2_pop_x4", 32'h00040000);
    pop_chk("t2_pop_x7", 32'h00070000);

    // Overfill by three
    cyc(0, 0, 1, '0, '0);
    decim = 8'd0;
    for (int i = 0; i < DEPTH + 3; i++) cyc(1, 0, 0, 16'(16'h0100 + i), 16'(16'h0A00 + i));
    idle();
    chk("t3_full", 64'(full), 64'd1);
    chk("t3_count", 64'(count), 64'(DEPTH));
    chk("t3_overflow", 64'(overflow), 64'd1);
    chk("t3_drop_cnt", 64'(drop_cnt), 64'd3);

    // Capture and pop together while full
    cyc(1, 1, 0, 16'hABCD, 16'h1234);
    idle();
    chk("t4_sim_valid", 64'(rd_valid), 64'd1);
    chk("t4_sim_data", 64'(rd_data), 64'h01000A00);
    chk("t4_sim_count", 64'(count), 64'(DEPTH));
    chk("t4_sim_drop", 64'(drop_cnt), 64'd3);
    for (int i = 1; i < DEPTH; i++) pop_chk("t4_pop", {16'(16'h0100 + i), 16'(16'h0A00 + i)});
    pop_chk("t4_pop_last", 32'hABCD1234);
    chk("t4_empty", 64'(empty), 64'd1);

    // Capture and pop together while empty
    cyc(1, 1, 0, 16'h7777, 16'h8888);
    idle();
    chk("t4e_valid", 64'(rd_valid), 64'd0);
    chk("t4e_count", 64'(count), 64'd1);
    pop_chk("t4e_pop", 32'h77778888);

    // Saturating drop counter, then clear with step and rd_req
    cyc(0, 0, 1, '0, '0);
    for (int i = 0; i < DEPTH + 300; i++) cyc(1, 0, 0, 16'(i), 16'(i));
    idle();
    chk("t5_drop_sat", 64'(drop_cnt), 64'd255);
    chk("t5_overflow", 64'(overflow), 64'd1);
    cyc(1, 1, 1, 16'hDEAD, 16'hBEEF);
    idle();
    chk("t5_clr_count", 64'(count), 64'd0);
    chk("t5_clr_empty", 64'(empty), 64'd1);
    chk("t5_clr_overflow", 64'(overflow), 64'd0);
    chk("t5_clr_drop", 64'(drop_cnt), 64'd0);
    chk("t5_clr_valid", 64'(rd_valid), 64'd0);
    chk("t5_clr_hold", 64'(rd_data), 64'h77778888);
    cyc(1, 0, 0, 16'h5555, 16'hAAAA);
    idle();
    chk("t5_after_count", 64'(count), 64'd1);
    pop_chk("t5_after_pop", 32'h5555AAAA);

    // Asynchronous reset in the middle of a read
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 16'(16'h0010 + i), 16'h00FF);
    cyc(0, 1, 0, '0, '0);
    @(posedge clk);
    #2;
    chk("t6_pre_valid", 64'(rd_valid), 64'd1);
    chk("t6_pre_data", 64'(rd_data), 64'h001000FF);
    rst = 1'b1;
    #1;
    chk_reset_vals("t6_async");
    rd_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 1, 0, '0, '0);
    idle();
    chk("t6_rd_after_rst", 64'(rd_valid), 64'd0);
    chk("t6_count_after_rst", 64'(count), 64'd0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
